// File: rtl/stencil_access_ctrl_pkg.sv
// Shared definitions for the stencil access controller.
// Optional feature macro: STENCIL_CLEAR_EN (hardware CLEAR_ALL sweep).
package stencil_access_ctrl_pkg;

    localparam int unsigned STENCIL_ADDR_W = 14;
    localparam int unsigned STENCIL_DEPTH  = 16384;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_TAS       = 2'd2,
        OP_CLEAR_ALL = 2'd3
    } stencil_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef STENCIL_CLEAR_EN
        ST_CLEAR  = 2'd2,
`endif
        ST_TAS_WR = 2'd1
    } stencil_state_e;

endpackage

// File: rtl/stencil_access_ctrl.sv
// Stencil bit-RAM access controller: READ / WRITE / TEST_AND_SET / CLEAR_ALL.
// Optional feature macro: STENCIL_CLEAR_EN. When undefined, CLEAR_ALL is a
// no-op that only pulses o_clear_done.
module stencil_access_ctrl
    import stencil_access_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      i_nrst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [1:0]                i_req_op,
    input  logic [STENCIL_ADDR_W-1:0] i_req_addr,
    input  logic                      i_req_bit,
    output logic                      o_rsp_valid,
    output logic                      o_rsp_bit,
    output logic                      o_clear_done,
    output logic [STENCIL_ADDR_W-1:0] o_mem_addr_wr,
    output logic [STENCIL_ADDR_W-1:0] o_mem_addr_rd,
    output logic                      o_mem_din,
    output logic                      o_mem_cs,
    output logic                      o_mem_we,
    input  logic                      i_mem_dout
);

    stencil_state_e              state_q;
    stencil_op_e                 req_op;
    logic [STENCIL_ADDR_W-1:0]   tas_addr_q;
    logic                        tas_bit_q;
    logic                        rsp_valid_q;
    logic                        clear_done_q;
    logic [STENCIL_ADDR_W-1:0]   addr_wr_q;
    logic [STENCIL_ADDR_W-1:0]   addr_wr_d;
    logic [STENCIL_ADDR_W-1:0]   addr_rd_q;
    logic [STENCIL_ADDR_W-1:0]   addr_rd_d;
    logic                        mem_cs_d;
    logic                        mem_we_d;
    logic                        mem_din_d;
`ifdef STENCIL_CLEAR_EN
    logic [STENCIL_ADDR_W-1:0]   cnt_q;
`endif

    assign req_op = stencil_op_e'(i_req_op);

    // RAM port drive: request passes straight through in IDLE so the access lands on the accepting edge
    always_comb begin
        mem_cs_d  = 1'b0;
        mem_we_d  = 1'b0;
        mem_din_d = 1'b0;
        addr_wr_d = addr_wr_q;
        addr_rd_d = addr_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    case (req_op)
                        OP_READ, OP_TAS: begin
                            mem_cs_d  = 1'b1;
                            addr_rd_d = i_req_addr;
                        end
                        OP_WRITE: begin
                            mem_cs_d  = 1'b1;
                            mem_we_d  = 1'b1;
                            addr_wr_d = i_req_addr;
                            mem_din_d = i_req_bit;
                        end
                        default: ;
                    endcase
                end
            end
            ST_TAS_WR: begin
                mem_cs_d  = 1'b1;
                mem_we_d  = 1'b1;
                addr_wr_d = tas_addr_q;
                mem_din_d = tas_bit_q;
            end
`ifdef STENCIL_CLEAR_EN
            ST_CLEAR: begin
                mem_cs_d  = 1'b1;
                mem_we_d  = 1'b1;
                addr_wr_d = cnt_q;
                mem_din_d = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Control FSM, request latches, response/done pulses and held RAM addresses
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= ST_IDLE;
            tas_addr_q   <= '0;
            tas_bit_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
            addr_wr_q    <= '0;
            addr_rd_q    <= '0;
`ifdef STENCIL_CLEAR_EN
            cnt_q        <= '0;
`endif
        end else begin
            addr_wr_q    <= addr_wr_d;
            addr_rd_q    <= addr_rd_d;
            rsp_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        case (req_op)
                            OP_READ: rsp_valid_q <= 1'b1;
                            OP_TAS: begin
                                rsp_valid_q <= 1'b1;
                                tas_addr_q  <= i_req_addr;
                                tas_bit_q   <= i_req_bit;
                                state_q     <= ST_TAS_WR;
                            end
                            OP_CLEAR_ALL: begin
`ifdef STENCIL_CLEAR_EN
                                cnt_q   <= '0;
                                state_q <= ST_CLEAR;
`else
                                clear_done_q <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_TAS_WR: state_q <= ST_IDLE;
`ifdef STENCIL_CLEAR_EN
                ST_CLEAR: begin
                    cnt_q <= cnt_q + STENCIL_ADDR_W'(1);
                    if (cnt_q == STENCIL_ADDR_W'(STENCIL_DEPTH - 1)) begin
                        state_q      <= ST_IDLE;
                        clear_done_q <= 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_bit     = i_mem_dout;
    assign o_clear_done  = clear_done_q;
    assign o_mem_cs      = mem_cs_d;
    assign o_mem_we      = mem_we_d;
    assign o_mem_din     = mem_din_d;
    assign o_mem_addr_wr = addr_wr_d;
    assign o_mem_addr_rd = addr_rd_d;

endmodule

// File: tb/tb_stencil_access_ctrl.sv
// Scoreboard bench for stencil_access_ctrl with a behavioural registered-read RAM.
// Follows STENCIL_CLEAR_EN so expectations match the build under test.
module tb_stencil_access_ctrl;
    import stencil_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [1:0]  i_req_op = 2'd0;
    logic [13:0] i_req_addr = '0;
    logic        i_req_bit = 1'b0;
    logic        o_rsp_valid;
    logic        o_rsp_bit;
    logic        o_clear_done;
    logic [13:0] o_mem_addr_wr;
    logic [13:0] o_mem_addr_rd;
    logic        o_mem_din;
    logic        o_mem_cs;
    logic        o_mem_we;
    logic        i_mem_dout = 1'b0;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;

    exp_t exp_rsp_q[$];
    int   exp_done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mem [STENCIL_DEPTH];

    stencil_access_ctrl dut (
        .clk          (clk),
        .i_nrst       (i_nrst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op     (i_req_op),
        .i_req_addr   (i_req_addr),
        .i_req_bit    (i_req_bit),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_bit    (o_rsp_bit),
        .o_clear_done (o_clear_done),
        .o_mem_addr_wr(o_mem_addr_wr),
        .o_mem_addr_rd(o_mem_addr_rd),
        .o_mem_din    (o_mem_din),
        .o_mem_cs     (o_mem_cs),
        .o_mem_we     (o_mem_we),
        .i_mem_dout   (i_mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read single-port bit RAM
    always @(posedge clk) begin
        if (o_mem_cs) begin
            if (o_mem_we) mem[o_mem_addr_wr] <= o_mem_din;
            else          i_mem_dout <= mem[o_mem_addr_rd];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses / done pulses whenever the DUT presents one
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (o_rsp_valid === 1'b1) begin
            if (exp_rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_bit", 32'(o_rsp_bit), 32'(e.b));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (o_clear_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_clear_done: got clear_done=1, expected none (cycle %0d)", cyc);
            end else begin
                dc = exp_done_q.pop_front();
                check("clear_done_cycle", 32'(cyc), 32'(dc));
            end
        end
    end

    // Drive one request (caller is 1 time unit after a rising edge); returns just after acceptance
    task automatic issue(input logic [1:0] op, input logic [13:0] addr, input logic b,
                         input logic exp_b, input bit track);
        int waited = 0;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_bit   = b;
        @(negedge clk);
        while (o_req_ready !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (o_req_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: got ready=0 after %0d cycles, expected 1", waited);
        end else begin
            case (op)
                2'd0, 2'd2: begin
                    check("mem_cs_we_rd", {30'd0, o_mem_cs, o_mem_we}, 32'd2);
                    check("mem_addr_rd", 32'(o_mem_addr_rd), 32'(addr));
                    if (track) exp_rsp_q.push_back('{b: exp_b, cyc: cyc + 1});
                end
                2'd1: begin
                    check("mem_cs_we_wr", {30'd0, o_mem_cs, o_mem_we}, 32'd3);
                    check("mem_addr_wr", 32'(o_mem_addr_wr), 32'(addr));
                end
                default: begin
`ifdef STENCIL_CLEAR_EN
                    if (track) exp_done_q.push_back(cyc + 1 + int'(STENCIL_DEPTH));
`else
                    check("clear_noop_cs", 32'(o_mem_cs), 32'd0);
                    if (track) exp_done_q.push_back(cyc + 1);
`endif
                end
            endcase
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low_cnt;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_clear_done", 32'(o_clear_done), 32'd0);
        check("rst_mem_cs", 32'(o_mem_cs), 32'd0);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        @(posedge clk);
        #3 i_nrst = 1'b1;
        @(posedge clk);
        #1;

        // WRITE then immediate READ of the same address
        issue(2'd1, 14'h1234, 1'b1, 1'b0, 1'b1);
        issue(2'd0, 14'h1234, 1'b0, 1'b1, 1'b1);

        // TEST_AND_SET on a stored 0, one busy cycle, then read back
        issue(2'd2, 14'h0005, 1'b1, 1'b0, 1'b1);
        check("tas_ready_low", 32'(o_req_ready), 32'd0);
        check("tas_wr_cs_we", {30'd0, o_mem_cs, o_mem_we}, 32'd3);
        check("tas_wr_addr", 32'(o_mem_addr_wr), 32'h0005);
        @(posedge clk);
        #1;
        check("tas_ready_back", 32'(o_req_ready), 32'd1);
        issue(2'd0, 14'h0005, 1'b0, 1'b1, 1'b1);

        // Back-to-back writes then back-to-back reads at 0..3
        issue(2'd1, 14'd0, 1'b1, 1'b0, 1'b1);
        issue(2'd1, 14'd1, 1'b0, 1'b0, 1'b1);
        issue(2'd1, 14'd2, 1'b1, 1'b0, 1'b1);
        issue(2'd1, 14'd3, 1'b1, 1'b0, 1'b1);
        issue(2'd0, 14'd0, 1'b0, 1'b1, 1'b1);
        issue(2'd0, 14'd1, 1'b0, 1'b0, 1'b1);
        issue(2'd0, 14'd2, 1'b0, 1'b1, 1'b1);
        issue(2'd0, 14'd3, 1'b0, 1'b1, 1'b1);

        // Idle: no access, read address holds
        @(negedge clk);
        check("idle_cs", 32'(o_mem_cs), 32'd0);
        check("idle_we", 32'(o_mem_we), 32'd0);
        check("idle_addr_rd_hold", 32'(o_mem_addr_rd), 32'd3);
        @(posedge clk);
        #1;

        // Reset during TAS_WR suppresses write and response
        issue(2'd2, 14'h0100, 1'b1, 1'b0, 1'b0);
        i_nrst = 1'b0;
        #1;
        check("tasrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("tasrst_cs", 32'(o_mem_cs), 32'd0);
        #1 i_nrst = 1'b1;
        @(posedge clk);
        #1;
        issue(2'd0, 14'h0100, 1'b0, 1'b0, 1'b1);

        // CLEAR_ALL after setting both boundary addresses
        issue(2'd1, 14'h3FFF, 1'b1, 1'b0, 1'b1);
        issue(2'd3, 14'd0, 1'b0, 1'b0, 1'b1);
`ifdef STENCIL_CLEAR_EN
        low_cnt = 0;
        @(negedge clk);
        while (o_req_ready !== 1'b1 && low_cnt < 20000) begin
            low_cnt++;
            @(negedge clk);
        end
        check("clear_busy_cycles", 32'(low_cnt), 32'(STENCIL_DEPTH));
        @(posedge clk);
        #1;
        issue(2'd0, 14'h0000, 1'b0, 1'b0, 1'b1);
        issue(2'd0, 14'h3FFF, 1'b0, 1'b0, 1'b1);

        // Reset mid-sweep: no done pulse, back to IDLE
        issue(2'd3, 14'd0, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("clear_mid_ready", 32'(o_req_ready), 32'd0);
        i_nrst = 1'b0;
        #1;
        check("clearrst_done", 32'(o_clear_done), 32'd0);
        check("clearrst_cs", 32'(o_mem_cs), 32'd0);
        #1 i_nrst = 1'b1;
        @(posedge clk);
        #1;
        check("clearrst_ready", 32'(o_req_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("clearrst_ready_late", 32'(o_req_ready), 32'd1);
`else
        low_cnt = 0;
        check("clear_noop_ready", 32'(o_req_ready), 32'd1);
        @(negedge clk);
        check("clear_noop_cs_after", 32'(o_mem_cs), 32'(low_cnt));
        @(posedge clk);
        #1;
        issue(2'd0, 14'h0000, 1'b0, 1'b1, 1'b1);
        issue(2'd0, 14'h3FFF, 1'b0, 1'b1, 1'b1);
`endif

        // Drain: every expected response and done pulse must have been seen
        repeat (5) @(negedge clk);
        check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
